// File: rtl/turn_signal_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : turn_signal_conditioner
// Brief    : Synchronizes and debounces the left/right turn switches, pairs
//            near-simultaneous presses into a hazard request, and publishes
//            L/R levels to the tail-light sequencer on a periodic step tick.
// Revision : 1.0  initial release
// ============================================================================
module turn_signal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 8,
  parameter int PAIR_WINDOW     = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_l,
  input  logic raw_r,
  output logic tick,
  output logic stable_l,
  output logic stable_r,
  output logic l_out,
  output logic r_out
);

  localparam int c_db_w   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_tick_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int c_win_w  = (PAIR_WINDOW > 2) ? $clog2(PAIR_WINDOW) : 1;

  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(PAIR_WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PAIR_WAIT = 2'd1,
    ST_ARMED     = 2'd2
  } state_t;

  // Bit 0 is the left channel, bit 1 the right channel.
  logic [1:0] w_raw;
  logic [1:0] w_stable;
  logic [1:0] w_flip;
  logic [1:0] w_rise;
  logic [1:0] w_stable_nxt;

  assign w_raw = {raw_r, raw_l};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_chan
      logic              r_sync1;
      logic              r_sync2;
      logic              r_stable;
      logic [c_db_w-1:0] r_cnt;
      logic              w_mismatch;

      assign w_mismatch      = r_sync2 ^ r_stable;
      assign w_flip[i]       = w_mismatch && (r_cnt == c_db_last);
      assign w_stable[i]     = r_stable;
      assign w_stable_nxt[i] = r_stable ^ w_flip[i];
      assign w_rise[i]       = w_flip[i] & ~r_stable;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync1  <= 1'b0;
          r_sync2  <= 1'b0;
          r_stable <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_sync1 <= w_raw[i];
          r_sync2 <= r_sync1;
          // Any cycle of agreement restarts the qualification run.
          if (!w_mismatch || w_flip[i]) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_flip[i]) begin
            r_stable <= ~r_stable;
          end
        end
      end
    end
  endgenerate

  logic [c_tick_w-1:0] r_tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == c_tick_last) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign tick = (r_tick_cnt == c_tick_last);

  state_t             r_state;
  logic [1:0]         r_pend;
  logic [c_win_w-1:0] r_win;
  logic               r_l_out;
  logic               r_r_out;

  // Tick actions are keyed off the pre-edge state; pend is only ever cleared
  // by publication so a press shorter than a tick period is still seen once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pend  <= 2'b00;
      r_win   <= '0;
      r_l_out <= 1'b0;
      r_r_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_rise) begin
            r_pend <= w_rise | w_stable_nxt;
            if (&(w_rise | w_stable_nxt)) begin
              r_state <= ST_ARMED;
            end else begin
              r_state <= ST_PAIR_WAIT;
              r_win   <= '0;
            end
          end else if (tick) begin
            r_l_out <= w_stable[0];
            r_r_out <= w_stable[1];
          end
        end
        ST_PAIR_WAIT: begin
          r_win <= r_win + 1'b1;
          if (tick) begin
            r_l_out <= 1'b0;
            r_r_out <= 1'b0;
          end
          if (|(w_rise & ~r_pend)) begin
            r_pend  <= r_pend | w_rise;
            r_state <= ST_ARMED;
          end else if (r_win == c_win_last) begin
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (tick) begin
            r_l_out <= r_pend[0];
            r_r_out <= r_pend[1];
            r_pend  <= 2'b00;
            r_state <= ST_IDLE;
          end else begin
            r_pend <= r_pend | w_rise;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stable_l = w_stable[0];
  assign stable_r = w_stable[1];
  assign l_out    = r_l_out;
  assign r_out    = r_r_out;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_signal_conditioner
// Brief    : Directed vector table plus hand sequences for the turn-signal
//            conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=8, PAIR_WINDOW=6.
// Revision : 1.0  initial release
// ============================================================================
module tb_turn_signal_conditioner;

  logic clk;
  logic reset;
  logic raw_l;
  logic raw_r;
  logic tick;
  logic stable_l;
  logic stable_r;
  logic l_out;
  logic r_out;

  int n_cmp;
  int n_bad;

  turn_signal_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (8),
    .PAIR_WINDOW    (6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_l   (raw_l),
    .raw_r   (raw_r),
    .tick    (tick),
    .stable_l(stable_l),
    .stable_r(stable_r),
    .l_out   (l_out),
    .r_out   (r_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bits: {tick, stable_l, stable_r, l_out, r_out}
  typedef struct {
    logic       rst;
    logic       l;
    logic       r;
    int         cyc;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] outs();
    return {tick, stable_l, stable_r, l_out, r_out};
  endfunction

  task automatic add(input logic rst, input logic l, input logic r,
                     input int cyc, input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.l = l; v.r = r; v.cyc = cyc; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking pulse; leaves the bench one posedge+1 after release.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    raw_l = 1'b0;
    raw_r = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    raw_l = 1'b0;
    raw_r = 1'b0;

    // Single side held
    add(1, 0, 0, 0, 5'b00000);
    add(0, 1, 0, 5, 5'b00000);
    add(0, 1, 0, 1, 5'b01000);
    add(0, 1, 0, 1, 5'b11000);
    add(0, 1, 0, 1, 5'b01000);
    add(0, 1, 0, 7, 5'b11000);
    add(0, 1, 0, 1, 5'b01010);
    add(0, 1, 0, 8, 5'b01010);
    // Right three cycles behind left: published together
    add(1, 0, 0, 0, 5'b00000);
    add(0, 1, 0, 3, 5'b00000);
    add(0, 1, 1, 5, 5'b01000);
    add(0, 1, 1, 1, 5'b01100);
    add(0, 1, 1, 6, 5'b11100);
    add(0, 1, 1, 1, 5'b01111);
    add(0, 1, 1, 8, 5'b01111);
    // Right ten cycles behind left: left alone first
    add(1, 0, 0, 0, 5'b00000);
    add(0, 1, 0, 10, 5'b01000);
    add(0, 1, 1, 5, 5'b11000);
    add(0, 1, 1, 1, 5'b01110);
    add(0, 1, 1, 8, 5'b01111);
    // Short press: published for exactly one tick period
    add(1, 0, 0, 0, 5'b00000);
    add(0, 1, 0, 7, 5'b11000);
    add(0, 0, 0, 6, 5'b00000);
    add(0, 0, 0, 2, 5'b10000);
    add(0, 0, 0, 1, 5'b00010);
    add(0, 0, 0, 7, 5'b10010);
    add(0, 0, 0, 1, 5'b00000);

    #2;
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        raw_l = vecs[i].l;
        raw_r = vecs[i].r;
        repeat (vecs[i].cyc) step();
      end
      check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end

    // Bounce on left: stable must hold 0, then rise 6 edges after last change
    do_reset();
    for (int k = 0; k < 20; k++) begin
      raw_l = ((k / 2) % 2 == 0);
      step();
      check($sformatf("bounce[%0d]", k), {4'b0, stable_l}, 5'b0);
    end
    raw_l = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("settle[%0d]", k), {4'b0, stable_l}, {4'b0, (k == 6)});
    end

    // Simultaneous press goes straight to ARMED and publishes at first tick
    do_reset();
    raw_l = 1'b1;
    raw_r = 1'b1;
    repeat (7) step();
    check("simul_n7", outs(), 5'b11100);
    step();
    check("simul_n8", outs(), 5'b01111);

    // Asynchronous reset mid-cycle clears everything before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 5'b00000);
    raw_l = 1'b0;
    raw_r = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("tick_n0", {4'b0, tick}, 5'b0);
    for (int n = 1; n <= 24; n++) begin
      step();
      check($sformatf("tick_n%0d", n), {4'b0, tick}, {4'b0, (n % 8 == 7)});
    end

    // Reset during PAIR_WAIT discards the pending left request
    do_reset();
    raw_l = 1'b1;
    repeat (8) step();
    check("pw_before_reset", outs(), 5'b01000);
    #2;
    reset = 1'b1;
    #1;
    check("pw_reset", outs(), 5'b00000);
    raw_l = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      check($sformatf("pw_quiet[%0d]", n), {3'b0, l_out, r_out}, 5'b0);
    end
    // A fresh right press follows the normal IDLE path
    raw_r = 1'b1;
    repeat (17) step();
    check("post_r_n47", {3'b0, l_out, r_out}, 5'b00000);
    step();
    check("post_r_n48", {3'b0, l_out, r_out}, 5'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
